wave_display_reader: RTL and testbench
======================================

Name: wave_display_reader

Overview:
- Read-side consumer of the double-buffered 512x8 waveform RAM that the capture block fills.
- Per VGA pixel, issues the RAM read address in the buffer half selected by read_index and receives the stored offset-binary sample.
- Draws a connected trace (vertical span between adjacent samples) inside a 512x512 window, and reports wave_display_idle back to the capture side.

Parameters:
- X0, 11'd256, left edge of the display window in pixels.
- WIN_W, 512, window width in pixels; 2 pixels per sample, 256 samples.
- WIN_H, 512, window height in pixels; 2 rows per plot step.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- x  in  11  current pixel column from the VGA timing block
- y  in  10  current pixel row
- valid  in  1  high when (x,y) is in the active video area
- read_index  in  1  buffer half the writer designates for reading
- read_value  in  8  RAM read data; synchronous RAM, valid 1 cycle after address
- read_address  out  9  {latched_index, sample_index} to RAM
- valid_pixel  out  1  pixel belongs to the window (pipelined)
- r, g, b  out  8 each  pixel colour
- wave_display_idle  out  1  high when not rendering the window

Behaviour:
- Reset values: valid_pixel=0, r=g=b=0, wave_display_idle=1, state=IDLE, latched_index=0, prev/cur sample regs=0, pipeline valids=0.
- Window hit (in_win): valid && X0<=x<X0+WIN_W && y<WIN_H.
- sample_index = (x-X0)[8:1], 8 bits. read_address = {latched_index, sample_index}, combinational from x. Outside the window, sample_index=0.
- Pipeline, 2-cycle latency:
  - Stage 0 (cycle n): address issued.
  - Stage 1 (n+1): read_value arrives. cur := 8'd255 - read_value, so larger samples plot higher.
  - Stage 2 (n+2): registered outputs.
  - x, y[8:1] and in_win are delayed alongside the data.
- Previous-sample register:
  - On stage-1 hit with x_d1==X0 (first pixel of a row): prev := cur, so no line is drawn from the left edge.
  - Otherwise prev := the old cur whenever sample_index_d1 differs from its previous value.
- Lit when in_win_d1 && min(prev,cur) <= y_d1[8:1] <= max(prev,cur), inclusive.
- Stage-2 outputs: valid_pixel=in_win_d1. r=g=b=8'hFF if lit, else 8'h00. Non-window pixels output 0.
- FSM (2 states):
  - IDLE: wave_display_idle=1; latched_index follows read_index every cycle. Go to RENDER when valid && x==X0 && y==0.
  - RENDER: wave_display_idle=0; latched_index frozen. Go to IDLE when valid && y==WIN_H (first row below the window).
  - wave_display_idle is registered and changes the cycle after the transition condition.
- Boundaries:
  - read_index toggling during RENDER has no effect until IDLE.
  - valid low: no FSM transitions, prev/cur hold, valid_pixel=0.
  - Adjacent samples 0x00 and 0xFF: full-height vertical span (rows 0..255 scaled).
  - Equal samples: a single lit row-pair.
  - x wrap to the next row resets the trace via the first-pixel rule.
  - Reset asserted mid-frame: immediately IDLE, idle=1, outputs 0. Rendering resumes only at the next (X0,0).
  - Frame start and end conditions in the same cycle are impossible (y differs); no priority needed.

Decomposition:
- Shared package: WIN_X0/WIN_W/WIN_H defaults; state encoding WD_IDLE=1'b0, WD_RENDER=1'b1; colour constants WD_ON=8'hFF, WD_OFF=8'h00.
- One sub-module: dffr_n, a parameterised width flop with asynchronous active-low reset and enable. Used for every register here.

Test Plan:
- Reset: hold reset=0 mid-frame -> wave_display_idle=1, valid_pixel=0, rgb=0. Release -> idle stays 1 until (x=256,y=0,valid=1), then 0 one cycle later.
- Addressing: read_index=1 latched in IDLE, x=256..259 -> read_address=0x100,0x100,0x101,0x101. Toggling read_index during RENDER leaves bit 8 at 1.
- Flat trace: RAM constant 0x80 -> cur=0x7F. Only rows y=254,255 lit per column, output 2 cycles after the input pixel.
- Steep edge: sample[5]=0x00, sample[6]=0xFF -> at x=268 all rows y=0..511 lit (span 0..255 scaled).
- Row start: last sample of row 0xFF, first of the next row 0x00 -> first pixel of the next row lights only rows 510,511, with no carry-over span.
- Frame end: y reaches 512 with valid=1 -> wave_display_idle rises the next cycle; a read_index change is then reflected on read_address[8] immediately.

Source files
------------

// File: rtl/wave_display_reader_pkg.sv
// Shared constants and types for the waveform display read path.
package wave_display_reader_pkg;
  localparam logic [10:0] WIN_X0 = 11'd256;
  localparam int          WIN_W  = 512;
  localparam int          WIN_H  = 512;

  typedef enum logic {
    WD_IDLE   = 1'b0,
    WD_RENDER = 1'b1
  } wd_state_e;

  localparam logic [7:0] WD_ON  = 8'hFF;
  localparam logic [7:0] WD_OFF = 8'h00;
endpackage

// File: rtl/dffr_n.sv
// Generic register with asynchronous active-low reset and load enable.
module dffr_n #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/wave_display_reader.sv
// Reads one buffer half of the waveform RAM per VGA pixel and draws a
// connected trace inside the display window, two cycles behind the pixel.
module wave_display_reader #(
  parameter logic [10:0] X0    = wave_display_reader_pkg::WIN_X0,
  parameter int          WIN_W = wave_display_reader_pkg::WIN_W,
  parameter int          WIN_H = wave_display_reader_pkg::WIN_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        valid,
  input  logic        read_index,
  input  logic [7:0]  read_value,
  output logic [8:0]  read_address,
  output logic        valid_pixel,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        wave_display_idle
);
  import wave_display_reader_pkg::*;

  localparam logic [11:0] X_LO  = {1'b0, X0};
  localparam logic [11:0] X_HI  = X_LO + 12'(WIN_W);
  localparam logic [9:0]  Y_END = 10'(WIN_H);

  function automatic logic in_span(input logic [7:0] row, input logic [7:0] a,
                                   input logic [7:0] c);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = (a < c) ? a : c;
    hi = (a < c) ? c : a;
    return (row >= lo) && (row <= hi);
  endfunction

  wd_state_e   state;
  wd_state_e   state_nxt;
  logic        state_q;
  logic        latched_index;
  logic        idle_nxt;
  logic        in_win;
  logic        frame_start;
  logic        frame_end;
  logic [10:0] x_off;
  logic [7:0]  sample_index;

  logic [10:0] x_p1;
  logic [7:0]  row_p1;
  logic [7:0]  si_p1;
  logic        vld_p1;
  logic [7:0]  si_last;
  logic [7:0]  cur_p1;
  logic [7:0]  prev_p1;
  logic [7:0]  cur_nxt;
  logic [7:0]  prev_nxt;
  logic        lit;
  logic [7:0]  rgb_p1;
  logic        vld_p2;
  logic [7:0]  rgb_p2;

  // Stage 0: window decode and RAM address
  assign in_win       = valid && ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) && (y < Y_END);
  assign x_off        = x - X0;
  assign sample_index = in_win ? 8'(x_off >> 1) : 8'd0;
  // While idle the buffer half tracks the writer directly; a frame freezes it.
  assign read_address = {(state == WD_IDLE) ? read_index : latched_index, sample_index};

  assign frame_start = valid && (x == X0) && (y == 10'd0);
  assign frame_end   = valid && (y == Y_END);
  assign state       = wd_state_e'(state_q);

  always_comb begin
    state_nxt = state;
    case (state)
      WD_IDLE:   if (frame_start) state_nxt = WD_RENDER;
      WD_RENDER: if (frame_end)   state_nxt = WD_IDLE;
      default:   state_nxt = WD_IDLE;
    endcase
  end
  assign idle_nxt = (state_nxt == WD_IDLE);

  dffr_n #(.DATA_W(1), .RST_VAL(1'b0)) u_state (.clk(clk), .rst_n(reset), .en(1'b1),
    .d(state_nxt), .q(state_q));
  dffr_n #(.DATA_W(1), .RST_VAL(1'b1)) u_idle (.clk(clk), .rst_n(reset), .en(1'b1),
    .d(idle_nxt), .q(wave_display_idle));
  dffr_n #(.DATA_W(1), .RST_VAL(1'b0)) u_lidx (.clk(clk), .rst_n(reset),
    .en(state == WD_IDLE), .d(read_index), .q(latched_index));

  dffr_n #(.DATA_W(11)) u_x_p1   (.clk(clk), .rst_n(reset), .en(1'b1), .d(x), .q(x_p1));
  dffr_n #(.DATA_W(8))  u_row_p1 (.clk(clk), .rst_n(reset), .en(1'b1), .d(y[8:1]), .q(row_p1));
  dffr_n #(.DATA_W(8))  u_si_p1  (.clk(clk), .rst_n(reset), .en(1'b1), .d(sample_index), .q(si_p1));
  dffr_n #(.DATA_W(1))  u_vld_p1 (.clk(clk), .rst_n(reset), .en(1'b1), .d(in_win), .q(vld_p1));

  // Stage 1: sample arrives; invert so larger samples plot higher
  always_comb begin
    cur_nxt  = 8'd255 - read_value;
    prev_nxt = prev_p1;
    if (x_p1 == X0)            prev_nxt = cur_nxt;
    else if (si_p1 != si_last) prev_nxt = cur_p1;
  end

  assign lit    = vld_p1 && in_span(row_p1, prev_nxt, cur_nxt);
  assign rgb_p1 = lit ? WD_ON : WD_OFF;

  dffr_n #(.DATA_W(8)) u_cur  (.clk(clk), .rst_n(reset), .en(vld_p1), .d(cur_nxt), .q(cur_p1));
  dffr_n #(.DATA_W(8)) u_prev (.clk(clk), .rst_n(reset), .en(vld_p1), .d(prev_nxt), .q(prev_p1));
  dffr_n #(.DATA_W(8)) u_sil  (.clk(clk), .rst_n(reset), .en(vld_p1), .d(si_p1), .q(si_last));

  // Stage 2: registered pixel outputs
  dffr_n #(.DATA_W(1)) u_vld_p2 (.clk(clk), .rst_n(reset), .en(1'b1), .d(vld_p1), .q(vld_p2));
  dffr_n #(.DATA_W(8)) u_rgb_p2 (.clk(clk), .rst_n(reset), .en(1'b1), .d(rgb_p1), .q(rgb_p2));

  assign valid_pixel = vld_p2;
  assign r = rgb_p2;
  assign g = rgb_p2;
  assign b = rgb_p2;
endmodule

// File: tb/tb_wave_display_reader.sv
// Scoreboard bench for wave_display_reader with a behavioural RAM and trace model.
module tb_wave_display_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [7:0]  read_value;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r, g, b;
  logic        wave_display_idle;

  always #5 clk = ~clk;

  wave_display_reader dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid),
    .read_index(read_index), .read_value(read_value), .read_address(read_address),
    .valid_pixel(valid_pixel), .r(r), .g(g), .b(b),
    .wave_display_idle(wave_display_idle)
  );

  // Synchronous RAM: data one cycle after the address.
  logic [7:0] mem [0:511];
  always @(posedge clk) read_value <= mem[read_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] exp;
  } chk_t;

  chk_t qa[$];
  chk_t qi[$];
  chk_t qp[$];
  chk_t qr[$];
  int tests = 0;
  int fails = 0;

  function automatic chk_t mk(input int d, input logic [31:0] e);
    chk_t c;
    c.due = d;
    c.exp = e;
    return c;
  endfunction

  task automatic check(input string name, input chk_t it, input logic [31:0] act);
    tests++;
    if (it.due != cyc) begin
      fails++;
      $display("FAIL %s late: due cycle %0d, checked at cycle %0d", name, it.due, cyc);
    end else if (act !== it.exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, it.exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    chk_t it;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      it = qa.pop_front();
      check("read_address", it, 32'(read_address));
    end
    while (qi.size() > 0 && qi[0].due <= cyc) begin
      it = qi.pop_front();
      check("idle", it, 32'(wave_display_idle));
    end
    while (qp.size() > 0 && qp[0].due <= cyc) begin
      it = qp.pop_front();
      check("pixel", it, 32'({valid_pixel, r, g, b}));
    end
    while (qr.size() > 0 && qr[0].due <= cyc) begin
      it = qr.pop_front();
      check("reset_outputs", it, 32'({wave_display_idle, valid_pixel, r, g, b}));
    end
    if (cyc > 90000) begin
      $display("FAIL watchdog: cycle budget exceeded at %0d", cyc);
      $fatal(1, "cycle budget exceeded");
    end
  end

  // Reference model: frame flag, buffer chosen at frame start, and the
  // sample values of the current and previously visited sample positions.
  logic m_active, m_lbuf;
  int   m_prev, m_cur, m_lidx;

  task automatic model_reset();
    m_active = 1'b0;
    m_lbuf   = 1'b0;
    m_prev   = 0;
    m_cur    = 0;
    m_lidx   = 0;
  endtask

  task automatic drive(input int px, input int py, input logic pv);
    int   bufsel, idx, s, lo, hi, row;
    logic hit, lit;
    x     = 11'(px);
    y     = 10'(py);
    valid = pv;
    bufsel = m_active ? int'(m_lbuf) : int'(read_index);
    hit    = pv && px >= 256 && px < 768 && py < 512;
    idx    = hit ? (px - 256) / 2 : 0;
    qa.push_back(mk(cyc, 32'(bufsel * 256 + idx)));
    lit = 1'b0;
    if (hit) begin
      s = 255 - int'(mem[bufsel * 256 + idx]);
      if (px == 256)          m_prev = s;
      else if (idx != m_lidx) m_prev = m_cur;
      m_cur  = s;
      m_lidx = idx;
      row = py / 2;
      lo  = (m_prev < m_cur) ? m_prev : m_cur;
      hi  = (m_prev < m_cur) ? m_cur : m_prev;
      lit = (row >= lo) && (row <= hi);
    end
    qp.push_back(mk(cyc + 2, 32'({hit, {3{lit ? 8'hFF : 8'h00}}})));
    if (!m_active) begin
      m_lbuf = read_index;
      if (pv && px == 256 && py == 0) m_active = 1'b1;
    end else if (pv && py == 512) begin
      m_active = 1'b0;
    end
    qi.push_back(mk(cyc + 1, 32'(!m_active)));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    qp.delete();
    qi.delete();
    qr.push_back(mk(cyc, 32'({1'b1, 1'b0, 24'd0})));
    model_reset();
    drive(0, 0, 1'b0);
    drive(0, 0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic row_span(input int py, input int xa, input int xb);
    for (int px = xa; px <= xb; px++) drive(px, py, 1'b1);
  endtask

  task automatic row_rand(input int py);
    logic v;
    for (int px = 250; px <= 772; px++) begin
      v = (px == 256) ? 1'b1 : ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) read_index = ~read_index;
      drive(px, py, v);
    end
  endtask

  initial begin
    int yy;
    reset = 1'b0;
    x = '0;
    y = '0;
    valid = 1'b0;
    read_index = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Addressing and frame start with buffer half 1
    read_index = 1'b1;
    drive(100, 0, 1'b1);
    drive(256, 0, 1'b1);
    drive(257, 0, 1'b1);
    drive(258, 0, 1'b1);
    drive(259, 0, 1'b1);
    read_index = 1'b0;
    row_span(0, 260, 270);

    // Flat trace: constant 0x80 in half 1
    for (int i = 256; i < 512; i++) mem[i] = 8'h80;
    row_span(253, 256, 299);
    row_span(254, 256, 299);
    row_span(255, 256, 299);
    row_span(256, 256, 299);

    // Steep edge between samples 5 and 6
    mem[256 + 5] = 8'h00;
    mem[256 + 6] = 8'hFF;
    row_span(0, 256, 279);
    row_span(300, 256, 279);
    row_span(511, 256, 279);

    // Frame end, then buffer half follows read_index at once
    drive(256, 512, 1'b1);
    drive(257, 512, 1'b1);
    read_index = 1'b1;
    drive(10, 600, 1'b0);
    read_index = 1'b0;
    drive(11, 600, 1'b0);
    drive(12, 600, 1'b1);

    // Row start: last sample 0xFF, first sample 0x00, no carry-over
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0]   = 8'h00;
    mem[255] = 8'hFF;
    row_span(0, 256, 767);
    row_span(509, 256, 767);
    row_span(510, 256, 263);
    row_span(509, 256, 767);
    row_span(300, 256, 263);
    row_span(511, 256, 263);
    drive(256, 512, 1'b1);

    // Reset in the middle of a frame
    drive(256, 0, 1'b1);
    row_span(2, 256, 300);
    do_reset();
    row_span(5, 256, 260);
    drive(256, 0, 1'b1);
    drive(257, 0, 1'b1);
    drive(256, 512, 1'b1);

    // Randomised frames
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
      read_index = 1'($urandom_range(0, 1));
      yy = 0;
      for (int k = 0; k < 7 && yy < 512; k++) begin
        row_rand(yy);
        yy += $urandom_range(1, 80);
      end
      drive(256, 512, 1'b1);
      for (int k = 0; k < 6; k++) drive($urandom_range(0, 1000), 520 + k, 1'($urandom_range(0, 1)));
    end

    repeat (4) drive(0, 600, 1'b0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
